muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EXE stage. It accepts MULT/MULTU/DIV/DIVU operations issued by the EXE pipe register and runs a 2-cycle multiply or a 32-iteration restoring divide. While it works it holds the stage's ready_go low, and it hands the 64-bit result to the HI/LO registers with a single write-enable pulse when MEM accepts the instruction. It replaces the single-cycle `mult` path and owns all HI/LO writes produced by arithmetic.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- start  in  1  EXE holds a valid mul/div op that has no pending exception (exe_valid & md_op & !ex_no_write)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs  in  32  operand A / dividend; sampled with start
- rt  in  32  operand B / divisor; sampled with start
- accept  in  1  MEM takes the instruction this cycle (mem_allowin)
- flush  in  1  cancel the in-flight op (flush_exe_mem)
- md_ready_go  out  1  result valid; EXE may advance
- busy  out  1  state != IDLE
- hilo_we  out  1  write hi_out/lo_out into HI and LO this cycle
- hi_out  out  32  product[63:32] / remainder
- lo_out  out  32  product[31:0] / quotient

## Operation
- Interface is decided: one clock `clk`; `rst` is synchronous and active-high.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and flush=0: latch op, rs, rt; clear the counter.
  - MULT/MULTU go to MUL.
  - DIV/DIVU with rt==0 go to DONE.
  - Other DIV/DIVU go to DIV.
- MUL:
  - Compute the 64-bit product: signed for MULT, unsigned for MULTU.
  - Register it into hi_out/lo_out and go to DONE.
- DIV:
  - Operate on magnitudes: for DIV, |rs| and |rt| (two's complement); for DIVU, raw values.
  - Record qneg = rs[31]^rt[31] and rneg = rs[31] (DIV only).
  - Each cycle performs one restoring step with a 33-bit partial remainder and shifts one quotient bit in.
  - The counter runs 0..31. At counter==31 the FSM goes to DONE and registers the sign-corrected results: lo = qneg ? -q : q, hi = rneg ? -r : r.
- Divide by zero: hi_out=rs (raw), lo_out=32'hFFFFFFFF.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural wrap.
- Quotient truncates toward zero; the remainder takes the dividend's sign.
- DONE:
  - md_ready_go=1.
  - If accept=1, assert hilo_we=1 and go to IDLE next edge.
  - If accept=0, hold DONE with results stable and hilo_we=0.
- start in MUL/DIV/DONE is ignored. Operand changes after latching are ignored.
- flush=1 in any state: IDLE on the next edge.
  - hilo_we is forced 0 that cycle.
  - flush has priority over start and over accept.
- rst: state IDLE, counter 0, all data registers 0.

## Timing
- Reset values: md_ready_go=0, busy=0, hilo_we=0, hi_out=0, lo_out=0.
- All outputs are combinational decodes of registered state; there are no input-to-output combinational paths except hilo_we (= DONE & accept & !flush).
- Take cycle 0 as the cycle in which start=1 in IDLE.
  - MUL: MUL in cycle 1, DONE in cycle 2. Best-case latency is 2 cycles.
  - DIV/DIVU: DIV in cycles 1..32, DONE in cycle 33.
  - Divide by zero: DONE in cycle 1.
- After an accept in DONE, the FSM is IDLE for one cycle. A back-to-back md op is sampled there, so issue-to-issue is latency+1 cycles.
- hilo_we is high for exactly one cycle per completed, unflushed op.
- Reset mid-operation aborts with no hilo_we. Next start is accepted the cycle after rst falls.

## Test plan
- MULT rs=0xFFFFFFFD, rt=5, accept=1: DONE at cycle 2 with hi=0xFFFFFFFF, lo=0xFFFFFFF1; hilo_we pulses once in cycle 2.
- DIVU rs=100, rt=7: busy cycles 1..33, md_ready_go only in cycle 33, lo=14, hi=2. Also DIV rs=-7 (0xFFFFFFF9), rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x12345678, rt=0: DONE at cycle 1 with hi=0x12345678, lo=0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU started, flush=1 at cycle 10: IDLE at cycle 11, no hilo_we ever asserted. A new MULTU 0xFFFFFFFF*2 issued at cycle 11 gives hi=1, lo=0xFFFFFFFE at cycle 13.
- MULTU 3*4 with accept=0 for cycles 2..4 and 1 at cycle 5: md_ready_go high cycles 2..5, hi/lo stable (0/12), hilo_we only in cycle 5, IDLE at cycle 6.
- rst asserted at DIV cycle 20: all outputs 0 the next cycle, busy=0, no hilo_we. start asserted together with flush in IDLE: no state change.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Handshake and data bundle between the EXE stage and the mul/div sequencer.
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        accept;
  logic        flush;
  logic        md_ready_go;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  // EXE side: issues ops and advances the pipe
  modport master (
    output start, op, rs, rt, accept, flush,
    input  md_ready_go, busy, hilo_we, hi_out, lo_out
  );

  // Sequencer side
  modport slave (
    input  start, op, rs, rt, accept, flush,
    output md_ready_go, busy, hilo_we, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EXE stage.
// Multiply takes one working cycle; divide is a 32-step restoring divider
// on magnitudes with sign correction on the final step. The 64-bit result
// is handed to HI/LO with a one-cycle write pulse when MEM accepts.
module muldiv_ctrl (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  md
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;      // multiplicand / dividend magnitude, becomes quotient
  logic [31:0] b_q, b_d;      // multiplier / divisor magnitude
  logic [32:0] rem_q, rem_d;  // partial remainder
  logic        sgn_q, sgn_d;  // signed op (MULT/DIV)
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] q_nxt;
  logic [32:0] r_nxt;
  logic [63:0] ext_a, ext_b, prod;
  logic        sgn_in;

  // Datapath helpers: one restoring step and the sign-extended product
  always_comb begin
    rem_sh = {rem_q[31:0], a_q[31]};
    diff   = rem_sh - {1'b0, b_q};
    q_nxt  = {a_q[30:0], ~diff[32]};
    r_nxt  = diff[32] ? rem_sh : diff;
    ext_a  = {{32{sgn_q & a_q[31]}}, a_q};
    ext_b  = {{32{sgn_q & b_q[31]}}, b_q};
    prod   = ext_a * ext_b;
    sgn_in = ~md.op[0];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        // A flushed start must not disturb any register, including HI/LO
        if (md.start && !md.flush) begin
          cnt_d  = '0;
          rem_d  = '0;
          sgn_d  = sgn_in;
          qneg_d = sgn_in & (md.rs[31] ^ md.rt[31]);
          rneg_d = sgn_in & md.rs[31];
          if (!md.op[1]) begin
            a_d     = md.rs;
            b_d     = md.rt;
            state_d = MUL;
          end else if (md.rt == '0) begin
            hi_d    = md.rs;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            a_d     = (sgn_in && md.rs[31]) ? -md.rs : md.rs;
            b_d     = (sgn_in && md.rt[31]) ? -md.rt : md.rt;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        state_d = DONE;
      end
      DIV: begin
        a_d   = q_nxt;
        rem_d = r_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          lo_d    = qneg_q ? -q_nxt : q_nxt;
          hi_d    = rneg_q ? -r_nxt[31:0] : r_nxt[31:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (md.accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (md.flush) state_d = IDLE;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy        = (state_q != IDLE);
  assign md.md_ready_go = (state_q == DONE);
  assign md.hilo_we     = (state_q == DONE) & md.accept & ~md.flush;
  assign md.hi_out      = hi_q;
  assign md.lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic model.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_ctrl_if md();
  muldiv_ctrl dut (.clk(clk), .rst(rst), .md(md));

  always #5 clk = ~clk;

  // Expected {hi, lo} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sq, sr;
    longint p;
    sa = a; sb = b;
    case (op)
      2'd0: begin p = longint'(sa) * longint'(sb); return p; end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = sa / sb; sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return 2;
    return (b == 0) ? 1 : 33;
  endfunction

  function automatic logic [31:0] rnd_div();
    return $urandom >> ($urandom % 32);
  endfunction

  // Issue one op in the current (IDLE) cycle, hold accept low for 'hold' DONE cycles
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    logic [63:0] exp;
    lat = latency(op, b);
    exp = model(op, a, b);
    md.start = 1'b1; md.op = op; md.rs = a; md.rt = b; md.accept = 1'b0; md.flush = 1'b0;
    checks++;
    if (md.busy !== 1'b0) begin errors++; $display("FAIL issue_idle op=%0d got busy=%b want 0", op, md.busy); end
    @(posedge clk); #1;
    md.start = 1'b0; md.rs = $urandom; md.rt = $urandom;
    for (int c = 1; c <= lat + hold; c++) begin
      md.accept = (c == lat + hold);
      #1;
      checks++;
      if (md.busy !== 1'b1 || md.md_ready_go !== (c >= lat)) begin
        errors++;
        $display("FAIL seq op=%0d cyc=%0d got busy=%b rdy=%b want busy=1 rdy=%b", op, c, md.busy, md.md_ready_go, c >= lat);
      end
      checks++;
      if (md.hilo_we !== (c == lat + hold)) begin
        errors++; $display("FAIL hilo_we op=%0d cyc=%0d got %b want %b", op, c, md.hilo_we, c == lat + hold);
      end
      if (c >= lat) begin
        checks++;
        if ({md.hi_out, md.lo_out} !== exp) begin
          errors++;
          $display("FAIL result op=%0d a=%h b=%h cyc=%0d got hi=%h lo=%h want hi=%h lo=%h",
                   op, a, b, c, md.hi_out, md.lo_out, exp[63:32], exp[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    md.accept = 1'b0;
    last_hi = exp[63:32]; last_lo = exp[31:0];
    checks++;
    if (md.busy !== 1'b0 || md.hilo_we !== 1'b0) begin
      errors++; $display("FAIL post_accept op=%0d got busy=%b we=%b want 0 0", op, md.busy, md.hilo_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    md.start = 1'b0; md.op = '0; md.rs = '0; md.rt = '0; md.accept = 1'b0; md.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({md.md_ready_go, md.busy, md.hilo_we} !== 3'b000 || md.hi_out !== 0 || md.lo_out !== 0) begin
      errors++;
      $display("FAIL reset got rdy=%b busy=%b we=%b hi=%h lo=%h want all 0",
               md.md_ready_go, md.busy, md.hilo_we, md.hi_out, md.lo_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op(2'd0, 32'hFFFFFFFD, 32'd5, 0);
    for (int i = 0; i < 8; i++) run_op(2'($urandom_range(0, 1)), $urandom, $urandom, 0);
  endtask

  task automatic test_div();
    run_op(2'd3, 32'd100, 32'd7, 0);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0);
    run_op(2'd2, 32'd7, 32'hFFFFFFFE, 0);
    for (int i = 0; i < 10; i++) run_op(2'($urandom_range(2, 3)), $urandom, rnd_div(), 0);
  endtask

  task automatic test_div_corner();
    run_op(2'd2, 32'h12345678, 32'd0, 0);
    run_op(2'd3, 32'hDEADBEEF, 32'd0, 0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'd3, 32'hFFFFFFFF, 32'd1, 0);
    run_op(2'd2, 32'h80000000, 32'd1, 0);
  endtask

  task automatic test_hold();
    run_op(2'd1, 32'd3, 32'd4, 3);
    run_op(2'd3, $urandom, rnd_div(), $urandom_range(1, 4));
  endtask

  task automatic test_flush();
    md.start = 1'b1; md.op = 2'd3; md.rs = $urandom; md.rt = 32'd9; md.accept = 1'b0; md.flush = 1'b0;
    @(posedge clk); #1;
    md.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      md.flush = (c == 10);
      md.accept = (c == 10);
      #1;
      checks++;
      if (md.busy !== 1'b1 || md.hilo_we !== 1'b0) begin
        errors++; $display("FAIL flush_div cyc=%0d got busy=%b we=%b want 1 0", c, md.busy, md.hilo_we);
      end
      @(posedge clk); #1;
    end
    md.flush = 1'b0; md.accept = 1'b0;
    checks++;
    if (md.busy !== 1'b0 || md.hilo_we !== 1'b0) begin
      errors++; $display("FAIL flush_idle got busy=%b we=%b want 0 0", md.busy, md.hilo_we);
    end
    run_op(2'd1, 32'hFFFFFFFF, 32'd2, 0);
    // Flush in DONE overrides accept
    md.start = 1'b1; md.op = 2'd1; md.rs = 32'd6; md.rt = 32'd7;
    @(posedge clk); #1;
    md.start = 1'b0;
    @(posedge clk); #1;
    md.accept = 1'b1; md.flush = 1'b1; #1;
    checks++;
    if (md.md_ready_go !== 1'b1 || md.hilo_we !== 1'b0) begin
      errors++; $display("FAIL flush_done got rdy=%b we=%b want 1 0", md.md_ready_go, md.hilo_we);
    end
    @(posedge clk); #1;
    md.accept = 1'b0; md.flush = 1'b0;
    checks++;
    if (md.busy !== 1'b0) begin errors++; $display("FAIL flush_done_idle got busy=%b want 0", md.busy); end
    last_hi = 32'd0; last_lo = 32'd42;
  endtask

  task automatic test_rst_mid();
    md.start = 1'b1; md.op = 2'd2; md.rs = $urandom; md.rt = 32'd3; md.accept = 1'b1; md.flush = 1'b0;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({md.md_ready_go, md.busy, md.hilo_we} !== 3'b000 || md.hi_out !== 0 || md.lo_out !== 0) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b busy=%b we=%b hi=%h lo=%h want all 0",
               md.md_ready_go, md.busy, md.hilo_we, md.hi_out, md.lo_out);
    end
    rst = 1'b0; md.accept = 1'b0;
    last_hi = '0; last_lo = '0;
    run_op(2'd0, $urandom, $urandom, 0);
  endtask

  task automatic test_start_flush();
    md.start = 1'b1; md.flush = 1'b1; md.op = 2'd2; md.rs = 32'hA5A5A5A5; md.rt = 32'd0;
    @(posedge clk); #1;
    md.start = 1'b0; md.flush = 1'b0;
    checks++;
    if (md.busy !== 1'b0 || md.md_ready_go !== 1'b0 || md.hi_out !== last_hi || md.lo_out !== last_lo) begin
      errors++;
      $display("FAIL start_flush got busy=%b rdy=%b hi=%h lo=%h want 0 0 hi=%h lo=%h",
               md.busy, md.md_ready_go, md.hi_out, md.lo_out, last_hi, last_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      run_op(op, $urandom, op[1] ? rnd_div() : $urandom, 0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_corner();
    test_hold();
    test_flush();
    test_rst_mid();
    test_start_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
